// File: rtl/bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e     : converter FSM states
//   DIGIT_W     : width of one BCD digit
//   BCD_W       : width of the hundreds/tens/units BCD shift register
//   ADD3_THRESH : digit value at and above which 3 is added before a shift
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned BCD_W       = 12;
  localparam int unsigned ADD3_THRESH = 5;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
//   d_i : BCD digit before correction (0..9)
//   d_o : corrected digit (never wraps, since d_i <= 9)
module bcd_add3
  import bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= DIGIT_W'(ADD3_THRESH)) begin
      d_o = d_i + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter with valid/ready
// handshakes on both sides. One operand is converted in WIDTH shift cycles;
// the result is presented as hundreds (1 bit), tens and units (4 bits each).
//   clk       : rising-edge clock
//   rst       : synchronous reset, active-high
//   in_valid  : producer presents operand a
//   in_ready  : converter idle and able to accept
//   a         : binary operand, sampled only on accept
//   out_valid : h/t/u hold a fresh result
//   out_ready : consumer takes the result
//   h, t, u   : hundreds, tens, units digits (registered, held until next result)
//   busy      : conversion in progress
module bcd_seq_converter
  import bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             h,
  output logic [3:0]       t,
  output logic [3:0]       u,
  output logic             busy
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 h_q, h_d;
  logic [DIGIT_W-1:0]   t_q, t_d;
  logic [DIGIT_W-1:0]   u_q, u_d;

  logic [DIGIT_W-1:0]   units_adj, tens_adj;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W+WIDTH-1:0] shift_all;
  logic [BCD_W-1:0]     bcd_shift;
  logic [WIDTH-1:0]     bin_shift;

  bcd_add3 u_add3_units (
    .d_i (bcd_q[DIGIT_W-1:0]),
    .d_o (units_adj)
  );

  bcd_add3 u_add3_tens (
    .d_i (bcd_q[2*DIGIT_W-1:DIGIT_W]),
    .d_o (tens_adj)
  );

  // Hundreds never reaches 5 for WIDTH <= 7, so it passes through uncorrected.
  assign bcd_adj   = {bcd_q[BCD_W-1:2*DIGIT_W], tens_adj, units_adj};
  assign shift_all = {bcd_adj, bin_q} << 1;
  assign bcd_shift = shift_all[BCD_W+WIDTH-1:WIDTH];
  assign bin_shift = shift_all[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    h_d     = h_q;
    t_d     = t_q;
    u_d     = u_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = a;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_shift;
        bin_d = bin_shift;
        cnt_d = cnt_q + CNT_W'(1);
        // Capture the digits straight from the final shift so they are
        // already stable on the first DONE cycle.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          h_d     = bcd_shift[2*DIGIT_W];
          t_d     = bcd_shift[2*DIGIT_W-1:DIGIT_W];
          u_d     = bcd_shift[DIGIT_W-1:0];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      h_q     <= 1'b0;
      t_q     <= '0;
      u_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      h_q     <= h_d;
      t_q     <= t_d;
      u_q     <= u_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign h         = h_q;
  assign t         = t_q;
  assign u         = u_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
module tb_bcd_seq_converter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] a;
  logic       out_valid;
  logic       out_ready;
  logic       h;
  logic [3:0] t;
  logic [3:0] u;
  logic       busy;

  int total = 0;
  int bad   = 0;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_seq_converter #(.WIDTH(7), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .h         (h),
    .t         (t),
    .u         (u),
    .busy      (busy)
  );

  typedef struct {
    logic [6:0] a;
    logic       h;
    logic [3:0] t;
    logic [3:0] u;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference digits straight from decimal arithmetic.
  function automatic int ref_h(input int v); return v / 100;        endfunction
  function automatic int ref_t(input int v); return (v / 10) % 10;  endfunction
  function automatic int ref_u(input int v); return v % 10;         endfunction

  // One full transaction: accept val, drive chg on a after accept, hold the
  // result for 'hold' cycles of backpressure, then consume it.
  task automatic convert(input logic [6:0] val, input logic [6:0] chg, input int hold,
                         output logic hh, output logic [3:0] tt, output logic [3:0] uu,
                         output int lat, output int bsy, output longint acc_cyc);
    bit ok;
    int n;
    in_valid  = 1'b1;
    a         = val;
    out_ready = 1'b0;
    ok = 0;
    n  = 0;
    while (!ok && n < 20) begin
      ok = in_ready;
      step();
      n++;
    end
    chk("accept", 32'(ok), 32'd1);
    acc_cyc  = cyc;
    in_valid = 1'b0;
    a        = chg;
    bsy = busy ? 1 : 0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
      if (busy) bsy++;
    end
    hh = h; tt = t; uu = u;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_inrdy", 32'(in_ready), 32'd0);
      chk("hold_digits", {23'd0, h, t, u}, {23'd0, hh, tt, uu});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("consume_valid", 32'(out_valid), 32'd0);
    chk("consume_inrdy", 32'(in_ready), 32'd1);
    chk("after_hold_digits", {23'd0, h, t, u}, {23'd0, hh, tt, uu});
  endtask

  vec_t   vecs[13];
  logic   rh;
  logic [3:0] rt, ru;
  int     lat, bsy, n;
  longint acc, prev_acc;
  int     v;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{7'd0,   1'b0, 4'd0, 4'd0};
    vecs[1]  = '{7'd127, 1'b1, 4'd2, 4'd7};
    vecs[2]  = '{7'd100, 1'b1, 4'd0, 4'd0};
    vecs[3]  = '{7'h41,  1'b0, 4'd6, 4'd5};
    vecs[4]  = '{7'h75,  1'b1, 4'd1, 4'd7};
    vecs[5]  = '{7'd99,  1'b0, 4'd9, 4'd9};
    vecs[6]  = '{7'd50,  1'b0, 4'd5, 4'd0};
    vecs[7]  = '{7'd18,  1'b0, 4'd1, 4'd8};
    vecs[8]  = '{7'd9,   1'b0, 4'd0, 4'd9};
    vecs[9]  = '{7'd10,  1'b0, 4'd1, 4'd0};
    vecs[10] = '{7'd19,  1'b0, 4'd1, 4'd9};
    vecs[11] = '{7'd90,  1'b0, 4'd9, 4'd0};
    vecs[12] = '{7'd101, 1'b1, 4'd0, 4'd1};

    rst = 1'b1; in_valid = 1'b0; a = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_digits",    {23'd0, h, t, u}, 32'd0);
    rst = 1'b0;
    step();
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // First operand: 7 shift cycles, out_valid on the 8th cycle counting the accept cycle.
    convert(7'd0, 7'd0, 0, rh, rt, ru, lat, bsy, acc);
    chk("zero_latency", lat, 7);
    chk("zero_digits", {23'd0, rh, rt, ru}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      convert(vecs[i].a, 7'($urandom), 0, rh, rt, ru, lat, bsy, acc);
      chk($sformatf("vec%0d_h", i), 32'(rh), 32'(vecs[i].h));
      chk($sformatf("vec%0d_t", i), 32'(rt), 32'(vecs[i].t));
      chk($sformatf("vec%0d_u", i), 32'(ru), 32'(vecs[i].u));
    end

    // Full sweep back-to-back, checked against decimal arithmetic.
    prev_acc = 0;
    for (int i = 0; i < 128; i++) begin
      convert(7'(i), 7'($urandom), 0, rh, rt, ru, lat, bsy, acc);
      chk($sformatf("sweep%0d", i), {23'd0, rh, rt, ru},
          32'((ref_h(i) << 8) | (ref_t(i) << 4) | ref_u(i)));
      if (i > 0) chk("sweep_spacing", 32'(acc - prev_acc), 32'd9);
      prev_acc = acc;
    end

    // Backpressure on 99.
    convert(7'd99, 7'd3, 5, rh, rt, ru, lat, bsy, acc);
    chk("bp_digits", {23'd0, rh, rt, ru}, 32'h099);

    // Operand change after accept is ignored; busy lasts exactly WIDTH cycles.
    convert(7'd18, 7'd127, 0, rh, rt, ru, lat, bsy, acc);
    chk("chg_digits", {23'd0, rh, rt, ru}, 32'h018);
    chk("chg_busy_cycles", bsy, 7);

    // Reset in the middle of a conversion.
    in_valid = 1'b1; a = 7'd127;
    step();
    chk("mid_accept_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy",   32'(busy),      32'd0);
    chk("mid_rst_valid",  32'(out_valid), 32'd0);
    chk("mid_rst_inrdy",  32'(in_ready),  32'd1);
    chk("mid_rst_digits", {23'd0, h, t, u}, 32'd0);
    n = 0;
    repeat (10) begin step(); if (out_valid) n++; end
    chk("mid_rst_no_valid", n, 0);
    convert(7'd50, 7'd0, 0, rh, rt, ru, lat, bsy, acc);
    chk("mid_rst_then50", {23'd0, rh, rt, ru}, 32'h050);

    // in_valid held through DONE is only accepted after the return to IDLE.
    in_valid = 1'b1; a = 7'd40; out_ready = 1'b0;
    step();
    a = 7'd33;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk("done_iv_first", {23'd0, h, t, u}, 32'h040);
    repeat (2) begin
      step();
      chk("done_iv_inrdy", 32'(in_ready), 32'd0);
      chk("done_iv_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("done_iv_no_bypass", 32'(busy), 32'd0);
    chk("done_iv_idle_rdy",  32'(in_ready), 32'd1);
    step();
    chk("done_iv_accepted", 32'(busy), 32'd1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk("done_iv_second", {23'd0, h, t, u}, 32'h033);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Randomized operands, changes and backpressure against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 127));
      convert(7'(v), 7'($urandom), int'($urandom_range(0, 3)), rh, rt, ru, lat, bsy, acc);
      chk($sformatf("rand%0d_a%0d", i, v), {23'd0, rh, rt, ru},
          32'((ref_h(v) << 8) | (ref_t(v) << 4) | ref_u(v)));
      chk("rand_latency", lat, 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
Sequential (shift-and-add-3, "double dabble") binary-to-BCD converter for 7-bit operands, with a valid/ready handshake on input and output. It replaces the combinational Mbinary2BCD tree where area matters, one conversion every WIDTH+1 cycles plus handshake overhead. It sits between a binary producer (counter/ALU) and a display or BCD consumer, and the FSM paces the shared add-3 datapath. Outputs keep the h/t/u split of Mbinary2BCD: hundreds 1 bit, tens 4 bits, units 4 bits.

Parameters:
WIDTH, 7, operand width in bits; legal 1..7, so max value 127 and hundreds never exceeds 1.
CNT_W, 3, iteration counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  producer presents operand
in_ready  out  1  converter can accept an operand
a  in  WIDTH  binary operand, sampled only on accept
out_valid  out  1  result h/t/u valid
out_ready  in  1  consumer takes result
h  out  1  hundreds digit (0 or 1)
t  out  4  tens digit (0..9)
u  out  4  units digit (0..9)
busy  out  1  high in SHIFT state

Behaviour:
- Reset (rst high at a clk edge):
  - state goes to IDLE; counter and shift register are cleared.
  - h, t and u become 0; out_valid and busy become 0; in_ready becomes 1 in the following cycle.
  - rst has priority over every other input, including mid-SHIFT and in DONE. Any partial or pending result is discarded.
- States: IDLE, SHIFT, DONE (2-bit encoded).
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid && in_ready at an edge. On accept: load bin_reg=a, bcd_reg=0 (12 bits: hundreds, tens, units nibbles), cnt=0, and go to SHIFT.
  - Without in_valid, stay in IDLE.
- SHIFT:
  - in_ready=0 and busy=1.
  - Each cycle, combinationally apply add-3 to the units and tens nibbles (nibble >=5 becomes nibble+3, 4-bit wrap-free because nibble <=9).
  - Then shift {bcd_reg,bin_reg} left by 1 and register the result; cnt increments by 1.
  - When cnt==WIDTH-1 at the edge, that shift is the last one: go to DONE.
  - Exactly WIDTH SHIFT cycles occur.
- DONE:
  - out_valid=1.
  - h=bcd_reg[8], t=bcd_reg[7:4], u=bcd_reg[3:0] are registered and stable while out_valid=1.
  - When out_ready is high at an edge, go to IDLE; out_valid drops in the next cycle.
  - No bypass: in_ready=0 throughout DONE, so a new operand cannot be accepted in the same cycle the result is consumed.
- Latency: with accept at edge N, out_valid is high from edge N+WIDTH+1 (WIDTH=7 gives 8 cycles).
  - With out_ready tied high, throughput is one result per WIDTH+2 cycles.
- Holding rules:
  - h, t and u hold their last result after out_valid falls, until the next DONE update.
  - Changes on a after accept are ignored.
  - in_valid may drop without being accepted; no state change results.
- Arithmetic:
  - bcd_reg[11:9] must stay 0 for WIDTH<=7.
  - The hundreds nibble needs no add-3 (it never reaches 5) but carries bit 8.
  - Zero-extended operands give identical results.
- Boundary values: a=0 gives 0/0/0; a=127 gives 1/2/7; a=100 gives 1/0/0.

Decomposition:
- Package bcd_seq_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the DIGIT_W=4 constant;
  - the BCD_W=12 constant;
  - the ADD3_THRESH=5 constant.
- Sub-module bcd_add3: 4-bit in, 4-bit out, output = in>=5 ? in+3 : in. Instantiate it twice (units and tens).

Test Plan:
- Reset, then in_valid=1 with a=0 and out_ready=1: out_valid rises 8 cycles after accept with h/t/u = 0/0/0, and in_ready returns 1 one cycle after consumption.
- Sweep a=0..127 back-to-back with out_ready=1: each result matches Mbinary2BCD as golden, e.g. 0x41 gives 0/6/5 and 0x75 gives 1/1/7; spacing is 9 cycles.
- Backpressure: a=99 with out_ready=0 for 5 cycles gives out_valid=1 held and 0/9/9 stable; in_ready stays 0 until one cycle after out_ready=1.
- Reset mid-operation: accept a=127, assert rst after 3 SHIFT cycles. Required: IDLE next cycle, outputs 0, no out_valid. A new a=50 then gives 0/5/0.
- Input change after accept: accept a=18, change a to 127 during SHIFT. Result must be 0/1/8, and busy must be high for exactly 7 cycles.
- in_valid asserted while in DONE is ignored; the operand is accepted only after the return to IDLE.
